// File: rtl/lfsr_bist_pkg.sv
// Shared types and constants for the 4-bit LFSR BIST sequencer.
package lfsr_bist_pkg;

    localparam int unsigned Width = 4;
    localparam logic [Width-1:0] DefTaps = 4'b1100;
    localparam logic [Width-1:0] DefSeed = 4'b1100;

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StRun,
        StCompare
    } bist_state_e;

endpackage

// File: rtl/lfsr4_step.sv
// One step of a 4-bit Fibonacci LFSR; with inj tied to zero it is a plain LFSR,
// otherwise a MISR folding the injected word into the shifted state.
module lfsr4_step
    import lfsr_bist_pkg::*;
#(
    parameter logic [Width-1:0] TAPS = DefTaps
) (
    input  logic [Width-1:0] cur,
    input  logic [Width-1:0] inj,
    output logic [Width-1:0] nxt
);

    assign nxt = {cur[Width-2:0], ^(cur & TAPS)} ^ inj;

endmodule

// File: rtl/lfsr_bist_controller.sv
// BIST sequencer: seeds an LFSR, drives NPAT patterns to the CUT, compacts the
// responses in a MISR and compares against golden. Optional: LFSR_LOCKUP_DETECT_EN.
module lfsr_bist_controller
    import lfsr_bist_pkg::*;
#(
    parameter logic [Width-1:0] TAPS = DefTaps,
    parameter logic [Width-1:0] SEED = DefSeed,
    parameter int unsigned      NPAT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [Width-1:0] seed_in,
    input  logic [Width-1:0] golden,
    input  logic [Width-1:0] cut_resp,
    output logic [Width-1:0] pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [Width-1:0] signature,
    output logic             lockup_err
);

    localparam logic [7:0] LastCnt = 8'(NPAT - 1);

    bist_state_e      state_q, state_d;
    logic [Width-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [Width-1:0] sig_q, sig_d, sig_step;
    logic [7:0]       cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
`ifdef LFSR_LOCKUP_DETECT_EN
    logic             lockup_q, lockup_d;
`endif

    lfsr4_step #(
        .TAPS (TAPS)
    ) u_lfsr_step (
        .cur (lfsr_q),
        .inj ({Width{1'b0}}),
        .nxt (lfsr_step)
    );

    lfsr4_step #(
        .TAPS (TAPS)
    ) u_misr_step (
        .cur (sig_q),
        .inj (cut_resp),
        .nxt (sig_step)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
`ifdef LFSR_LOCKUP_DETECT_EN
        lockup_d = lockup_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StSeed;
                    lfsr_d  = seed_load ? seed_in : SEED;
`ifdef LFSR_LOCKUP_DETECT_EN
                    lockup_d = 1'b0;
`endif
                end
            end
            StSeed: begin
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else begin
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = StRun;
`ifdef LFSR_LOCKUP_DETECT_EN
                    // An all-zero LFSR never leaves zero; end the run at once.
                    if (lfsr_q == '0) begin
                        lockup_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = StIdle;
                    end
`endif
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else begin
                    lfsr_d = lfsr_step;
                    sig_d  = sig_step;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == LastCnt) begin
                        state_d = StCompare;
                    end
                end
            end
            StCompare: begin
                state_d = StIdle;
                if (abort) begin
                    pass_d = 1'b0;
                end else begin
                    pass_d = (sig_q == golden);
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

`ifdef LFSR_LOCKUP_DETECT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign lockup_err = lockup_q;
`else
    assign lockup_err = 1'b0;
`endif

    assign pattern       = lfsr_q;
    assign signature     = sig_q;
    assign pattern_valid = (state_q == StRun);
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign pass          = pass_q;

endmodule
